// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serialiser (8E1 when UART_TX_PARITY_EN is defined).
// States: IDLE (pop head when FIFO non-empty) | START | DATA (8 bits, LSB first) | PARITY (optional) | STOP
module uart_tx_fifo #(
    parameter int unsigned BAUD_DIV   = 104,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  clr_ovf,
    output logic                  tx,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  busy,
    output logic                  overflow
);

    localparam int unsigned           DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [15:0]           BAUD_LAST = 16'(BAUD_DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [7:0]             r_mem [DEPTH];
    logic [DEPTH_LOG2:0]    r_wr_ptr;
    logic [DEPTH_LOG2:0]    r_rd_ptr;
    logic [DEPTH_LOG2:0]    w_wr_ptr_nxt;
    logic [DEPTH_LOG2:0]    w_rd_ptr_nxt;
    logic [DEPTH_LOG2:0]    w_count_nxt;
    logic [DEPTH_LOG2:0]    r_count;
    logic                   r_full;
    logic                   r_empty;
    logic                   r_overflow;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drop;
    logic [7:0]             w_head;

    logic [15:0]            r_baud_cnt;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;
    logic                   w_bit_done;
`ifdef UART_TX_PARITY_EN
    logic                   r_parity;
`endif

    // Full flag is the registered one, so a push at full is dropped even if a pop frees a slot this cycle.
    assign w_push       = wr_en & ~r_full;
    assign w_drop       = wr_en & r_full;
    assign w_pop        = (r_state == ST_IDLE) & ~r_empty;
    assign w_wr_ptr_nxt = r_wr_ptr + (DEPTH_LOG2 + 1)'(w_push);
    assign w_rd_ptr_nxt = r_rd_ptr + (DEPTH_LOG2 + 1)'(w_pop);
    assign w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
    assign w_head       = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
    assign w_bit_done   = (r_baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == DEPTH_CNT);
            r_empty  <= (w_count_nxt == '0);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (!r_empty)   w_state_nxt = ST_START;
            ST_START:  if (w_bit_done) w_state_nxt = ST_DATA;
            ST_DATA: begin
                if (w_bit_done && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = ST_PARITY;
`else
                    w_state_nxt = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (w_bit_done) w_state_nxt = ST_STOP;
`endif
            ST_STOP:   if (w_bit_done) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else if (r_state == ST_IDLE) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            if (w_pop) begin
                r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                r_parity <= ^w_head;
`endif
            end
        end else if (w_bit_done) begin
            r_baud_cnt <= '0;
            if (r_state == ST_DATA) begin
                r_shift   <= r_shift >> 1;
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
        end
    end

    always_comb begin
        tx   = 1'b1;
        busy = (r_state != ST_IDLE);
        case (r_state)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = r_shift[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx = r_parity;
`endif
            default:   tx = 1'b1;
        endcase
    end

    assign full     = r_full;
    assign empty    = r_empty;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: scoreboard of queued bytes checked against frames seen on tx.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_fifo;

    localparam int BD  = 4;
    localparam int DL2 = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           wr_en = 1'b0;
    logic [7:0]     wr_data = 8'h00;
    logic           clr_ovf = 1'b0;
    logic           tx;
    logic           full;
    logic           empty;
    logic [DL2:0]   count;
    logic           busy;
    logic           overflow;

    int             n_tests = 0;
    int             n_fail = 0;
    logic [7:0]     sb_q[$];

    uart_tx_fifo #(.BAUD_DIV(BD), .DEPTH_LOG2(DL2)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
        .tx(tx), .full(full), .empty(empty), .count(count), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic frame_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Called at a negedge; drives one push across the next posedge, returns at the following negedge.
    task automatic push_byte(input logic [7:0] d, input bit accepted);
        wr_en   = 1'b1;
        wr_data = d;
        if (accepted) sb_q.push_back(d);
        @(negedge clk);
        wr_en   = 1'b0;
        wr_data = ~d;
    endtask

    task automatic wait_start(input string name, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (tx === 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL %s_start: got no start bit, required one within %0d cycles", name, limit); end
    endtask

    // Current negedge is the first cycle of the start bit; returns at the negedge after the stop bit.
    task automatic check_frame(input string name);
        logic [7:0] exp_d;
        logic [7:0] got;
        int         bad;
        bad = 0;
        got = 8'h00;
        exp_d = 8'h00;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++; $display("FAIL %s_sb: got frame, required none (scoreboard empty)", name);
        end else begin
            exp_d = sb_q.pop_front();
        end
        for (int c = 0; c < NB*BD; c++) begin
            if (c != 0) @(negedge clk);
            if (tx !== frame_bit(exp_d, c/BD) || busy !== 1'b1) bad++;
            if (c/BD >= 1 && c/BD <= 8 && c%BD == BD/2) got[c/BD-1] = tx;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL %s_bits: got %0d bad cycles, required 0 (byte %h)", name, bad, exp_d); end
        n_tests++;
        if (got !== exp_d) begin n_fail++; $display("FAIL %s_byte: got %h required %h", name, got, exp_d); end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            n_fail++; $display("FAIL %s_end: got busy=%b tx=%b required busy=0 tx=1", name, busy, tx);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if (tx !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_hold: got tx=%b busy=%b required 1 0", tx, busy); end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (tx !== 1'b1)       begin n_fail++; $display("FAIL rst_tx: got %b required 1", tx); end
        n_tests++; if (full !== 1'b0)     begin n_fail++; $display("FAIL rst_full: got %b required 0", full); end
        n_tests++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL rst_empty: got %b required 1", empty); end
        n_tests++; if (count !== 5'd0)    begin n_fail++; $display("FAIL rst_count: got %0d required 0", count); end
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b required 0", overflow); end
    endtask

    task automatic test_single();
        push_byte(8'h55, 1'b1);
        n_tests++; if (empty !== 1'b0 || count !== 5'd1) begin n_fail++; $display("FAIL single_n1: got empty=%b count=%0d required 0 1", empty, count); end
        n_tests++; if (tx !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_n1_tx: got tx=%b busy=%b required 1 0", tx, busy); end
        @(negedge clk);
        n_tests++; if (tx !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_n2_tx: got tx=%b busy=%b required 0 1", tx, busy); end
        n_tests++; if (empty !== 1'b1 || count !== 5'd0) begin n_fail++; $display("FAIL single_n2_empty: got empty=%b count=%0d required 1 0", empty, count); end
        check_frame("single");
    endtask

    task automatic test_back_to_back();
        push_byte(8'hA3, 1'b1);
        push_byte(8'h0F, 1'b1);
        n_tests++; if (tx !== 1'b0) begin n_fail++; $display("FAIL b2b_first: got tx=%b required 0", tx); end
        check_frame("b2b_a3");
        @(negedge clk);
        n_tests++; if (tx !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got tx=%b required 0 after one idle cycle", tx); end
        check_frame("b2b_0f");
    endtask

    task automatic test_overflow();
        bit seen;
        for (int i = 0; i <= 16; i++) push_byte(8'(i), 1'b1);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_fill: got %b required 0", overflow); end
        n_tests++; if (count !== 5'd16 || full !== 1'b1) begin n_fail++; $display("FAIL ovf_fill_count: got %0d full=%b required 16 1", count, full); end
        for (int i = 0; i <= 16; i++) push_byte(8'h80 + 8'(i), 1'b0);
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b required 1", overflow); end
        n_tests++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count: got %0d required 16", count); end
        clr_ovf = 1'b1;
        @(negedge clk);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b required 0", overflow); end
        wr_en = 1'b1; wr_data = 8'hC5;
        @(negedge clk);
        wr_en = 1'b0;
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b required 1", overflow); end
        @(negedge clk);
        clr_ovf = 1'b0;
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr2: got %b required 0", overflow); end

        // Push at full in the very cycle the transmitter pops.
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (busy === 1'b0) seen = 1'b1;
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL popfull_wait: got busy stuck, required idle within 100 cycles"); end
        n_tests++; if (count !== 5'd16) begin n_fail++; $display("FAIL popfull_pre: got %0d required 16", count); end
        void'(sb_q.pop_front());
        push_byte(8'hEE, 1'b0);
        n_tests++; if (count !== 5'd15 || full !== 1'b0) begin n_fail++; $display("FAIL popfull_count: got %0d full=%b required 15 0", count, full); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL popfull_ovf: got %b required 1", overflow); end
        n_tests++; if (tx !== 1'b0) begin n_fail++; $display("FAIL popfull_start: got tx=%b required 0", tx); end
        check_frame("drain");
        for (int i = 0; i < 15; i++) begin
            wait_start("drain", 5);
            check_frame("drain");
        end
        n_tests++; if (sb_q.size() != 0 || empty !== 1'b1) begin n_fail++; $display("FAIL drain_done: got %0d left empty=%b required 0 1", sb_q.size(), empty); end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int bad;
        push_byte(8'h00, 1'b1);
        push_byte(8'h11, 1'b1);
        push_byte(8'h22, 1'b1);
        repeat (4*BD - 2) @(negedge clk);
        n_tests++; if (tx !== 1'b0 || count !== 5'd2) begin n_fail++; $display("FAIL midrst_pre: got tx=%b count=%0d required 0 2", tx, count); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (tx !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_tx: got tx=%b busy=%b required 1 0", tx, busy); end
        n_tests++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL midrst_fifo: got count=%0d empty=%b full=%b required 0 1 0", count, empty, full); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || empty !== 1'b1) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL midrst_after: got %0d active cycles required 0", bad); end
    endtask

    task automatic test_patterns();
        logic [7:0] pats [4];
        pats = '{8'h07, 8'h03, 8'hFF, 8'h80};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            push_byte(pats[i], 1'b1);
            wait_start("pattern", 5);
            check_frame("pattern");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_patterns();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered UART transmitter that sits directly downstream of the communication block's register decode. It consumes the byte written by the CPU to the UART0 data register. Written bytes are queued in a FIFO and serialised onto the TX pin as 8N1 frames, LSB first, at a rate set by a clock divider. Status outputs (full/empty/count/busy/overflow) feed the communication block's status register and interrupt logic.

Parameters:
BAUD_DIV, 104, clk cycles per bit (mclk 1 MHz / 104 ≈ 9600 baud); legal range 2..65535
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (default 16)

Ports:
clk  input  1  master clock (mclk)
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  push wr_data into FIFO this cycle
wr_data  input  8  byte to transmit
clr_ovf  input  1  clear sticky overflow flag
tx  output  1  UART serial output, idle high
full  output  1  FIFO holds 2**DEPTH_LOG2 entries
empty  output  1  FIFO holds 0 entries
count  output  DEPTH_LOG2+1  current FIFO occupancy
busy  output  1  high while a frame is being shifted (FSM not IDLE)
overflow  output  1  sticky: a write was dropped because FIFO was full

Behaviour:
- Reset values (async, rst_n low): tx=1, full=0, empty=1, count=0, busy=0, overflow=0, FSM=IDLE, FIFO pointers=0, baud counter=0. Reset mid-frame aborts the frame, drives tx=1 immediately and flushes the FIFO.
- FIFO: circular buffer, read/write pointers DEPTH_LOG2+1 bits wide, wrap modulo 2*depth; full/empty/count derived from the pointers and registered in the same cycle as the pointer update.
- Push: wr_en=1 and full=0 (value at the start of the cycle) → byte stored; count increments next cycle.
- Push with full=1 → byte dropped, overflow=1 next cycle, even if a pop occurs in the same cycle.
- Simultaneous push (not full) and pop → count unchanged, both take effect.
- overflow: set by a dropped write; cleared by clr_ovf. If clr_ovf and a dropped write happen in the same cycle, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, busy=0. If empty=0 → pop head into 8-bit shift register, baud counter=0, go to START.
  - START: tx=0 for BAUD_DIV cycles, then DATA with bit index=0.
  - DATA: tx=shift[0] for BAUD_DIV cycles, then shift right and increment the index. After bit index 7 completes → STOP.
  - STOP: tx=1 for BAUD_DIV cycles, then IDLE.
- busy=1 in START/DATA/STOP.
- Latency: a push into an empty FIFO while in IDLE at cycle N makes empty=0 at N+1. The pop occurs at N+1 and tx falls at N+2.
- Frame length: exactly 10*BAUD_DIV cycles of tx activity. Back-to-back frames are separated by exactly 1 idle cycle (the IDLE pop cycle, tx=1).
- Baud counter counts 0..BAUD_DIV-1 and wraps to 0 on each bit boundary. It must be wide enough for 65535 (16 bits).
- wr_data is sampled only on an accepted push; later changes do not affect queued bytes.

Optional Feature:
UART_TX_PARITY_EN:
- Defined: frame is 8E1. A PARITY state is inserted between DATA and STOP; it drives the even-parity bit (XOR of the 8 data bits) for BAUD_DIV cycles. Frame length becomes 11*BAUD_DIV.
- Undefined: 8N1 as above; the PARITY state and its logic do not exist.

Test Plan:
- BAUD_DIV=4, reset released, push 0x55 at cycle N → tx low at N+2 for 4 cycles, then bits 1,0,1,0,1,0,1,0 (4 cycles each), stop high 4 cycles; busy high for 40 cycles; empty=1 from N+2.
- Push 17 bytes 0x00..0x10 on consecutive cycles with the transmitter stalled behind the first frame → first pop frees one slot, so all 17 are accepted and overflow=0. Then push 17 more with full=1 → overflow=1 and count=16; clr_ovf → overflow=0 next cycle.
- Push 0xA3 then 0x0F back-to-back, BAUD_DIV=4 → two 40-cycle frames on tx with exactly 1 cycle of tx=1 between the stop bit of frame 1 and the start bit of frame 2; decoded bytes are 0xA3, 0x0F.
- Queue 3 bytes, assert rst_n=0 during bit 3 of the first frame → tx=1, count=0, empty=1, busy=0 asynchronously. After release, tx stays 1 with no residual frame.
- Push at full while a pop happens in the same cycle → byte dropped, overflow=1, count=15 next cycle.
- UART_TX_PARITY_EN defined, BAUD_DIV=4, push 0x07 → parity bit=1 after the data bits, frame length 44 cycles; push 0x03 → parity bit=0.
